// File: rtl/karatsuba_mul.sv
// One-level Karatsuba multiplier, N-bit operands, 2N-bit product, unsigned or signed per op.
// A single (H+1)x(H+1) multiplier is time-shared across the three partial products.
module karatsuba_mul #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [N-1:0]   X,
    input  logic [N-1:0]   Y,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] R
);
    localparam int H = N / 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MA   = 3'd1,
        ST_MB   = 3'd2,
        ST_MC   = 3'd3,
        ST_CB   = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [N-1:0]     x_mag_r, y_mag_r;
    logic             neg_r;
    logic [2*H-1:0]   a_r, b_r;
    logic [2*H+1:0]   c_r;
    logic [2*N-1:0]   r_r;
    logic             done_r, busy_r;

    logic [N-1:0]     x_mag_s, y_mag_s;
    logic [H:0]       mul_a_s, mul_b_s;
    logic [2*H+1:0]   mul_p_s;
    logic [2*H+1:0]   m_s;
    logic [2*N-1:0]   p_s, res_s;

    // Operand magnitudes; negating -2^(N-1) wraps to 2^(N-1), which is its correct magnitude.
    always_comb begin
        x_mag_s = X;
        y_mag_s = Y;
        if (sgn && X[N-1]) begin
            x_mag_s = -X;
        end else begin
            x_mag_s = X;
        end
        if (sgn && Y[N-1]) begin
            y_mag_s = -Y;
        end else begin
            y_mag_s = Y;
        end
    end

    // Shared multiplier operand select by state.
    always_comb begin
        mul_a_s = {(H+1){1'b0}};
        mul_b_s = {(H+1){1'b0}};
        case (state_r)
            ST_MA: begin
                mul_a_s = {1'b0, x_mag_r[N-1:H]};
                mul_b_s = {1'b0, y_mag_r[N-1:H]};
            end
            ST_MB: begin
                mul_a_s = {1'b0, x_mag_r[H-1:0]};
                mul_b_s = {1'b0, y_mag_r[H-1:0]};
            end
            ST_MC: begin
                mul_a_s = {1'b0, x_mag_r[N-1:H]} + {1'b0, x_mag_r[H-1:0]};
                mul_b_s = {1'b0, y_mag_r[N-1:H]} + {1'b0, y_mag_r[H-1:0]};
            end
            default: begin
                mul_a_s = {(H+1){1'b0}};
                mul_b_s = {(H+1){1'b0}};
            end
        endcase
    end

    assign mul_p_s = {{(H+1){1'b0}}, mul_a_s} * {{(H+1){1'b0}}, mul_b_s};

    // Recombination: middle term is non-negative and the full sum is exact in 2N bits.
    always_comb begin
        m_s   = c_r - {2'b00, a_r} - {2'b00, b_r};
        p_s   = {a_r, {N{1'b0}}} + ({{(N-2){1'b0}}, m_s} << H) + {{N{1'b0}}, b_r};
        res_s = p_s;
        if (neg_r) begin
            res_s = {(2*N){1'b0}} - p_s;
        end else begin
            res_s = p_s;
        end
    end

    // Next-state sequencing; one cycle per datapath step.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_MA;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MA:   state_next_s = ST_MB;
            ST_MB:   state_next_s = ST_MC;
            ST_MC:   state_next_s = ST_CB;
            ST_CB:   state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            x_mag_r <= {N{1'b0}};
            y_mag_r <= {N{1'b0}};
            neg_r   <= 1'b0;
            a_r     <= {(2*H){1'b0}};
            b_r     <= {(2*H){1'b0}};
            c_r     <= {(2*H+2){1'b0}};
            r_r     <= {(2*N){1'b0}};
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_r == ST_CB);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        x_mag_r <= x_mag_s;
                        y_mag_r <= y_mag_s;
                        neg_r   <= sgn & (X[N-1] ^ Y[N-1]);
                    end
                end
                ST_MA:   a_r <= mul_p_s[2*H-1:0];
                ST_MB:   b_r <= mul_p_s[2*H-1:0];
                ST_MC:   c_r <= mul_p_s;
                ST_CB:   r_r <= res_s;
                default: r_r <= r_r;
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign R    = r_r;
endmodule

// File: tb/tb_karatsuba_mul.sv
// Scoreboard bench for karatsuba_mul (N=16): directed vectors plus random ops,
// expected products pushed at issue time and checked by an independent done monitor.
module tb_karatsuba_mul;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [15:0] X = 16'h0000;
    logic [15:0] Y = 16'h0000;
    logic        busy, done;
    logic [31:0] R;

    logic [31:0] sb[$];
    int n_chk = 0;
    int n_fail = 0;

    karatsuba_mul #(.N(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn),
        .X(X), .Y(Y), .busy(busy), .done(done), .R(R)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [31:0] ea, eb;
        ea = s ? {{16{a[15]}}, a} : {16'h0000, a};
        eb = s ? {{16{b[15]}}, b} : {16'h0000, b};
        return ea * eb;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", R, 32'hxxxxxxxx);
            end else begin
                chk("product", R, sb.pop_front());
            end
        end
    end

    // Called #1 after a posedge with the DUT idle; returns #1 after the capture edge.
    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic s, input logic [31:0] e);
        X = x; Y = y; sgn = s; start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < 20);
        if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    int cyc, busy_cnt, done_cnt;
    logic [15:0] rx, ry;
    logic        rs;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_R", R, 32'h0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: latency and single-cycle done
        issue(16'h1234, 16'h5678, 1'b0, 32'h06260060);
        wait_done(cyc);
        chk("latency", cyc, 32'd4);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        // 2,3: carry extremes and signedness
        issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001); wait_done(cyc);
        issue(16'h8000, 16'h8000, 1'b1, 32'h40000000); wait_done(cyc);
        issue(16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF); wait_done(cyc);
        issue(16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF); wait_done(cyc);
        issue(16'h0000, 16'hBEEF, 1'b1, 32'h00000000); wait_done(cyc);
        issue(16'h7FFF, 16'h8000, 1'b1, 32'hC0008000); wait_done(cyc);

        // 4: start and operand change mid-op are ignored; busy for exactly 4 samples
        issue(16'h1234, 16'h5678, 1'b0, 32'h06260060);
        busy_cnt = busy ? 1 : 0;
        @(posedge clk); #1;
        busy_cnt += busy ? 1 : 0;
        X = 16'hFFFF; sgn = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        busy_cnt += busy ? 1 : 0;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            busy_cnt += busy ? 1 : 0;
        end
        chk("busy_cycles", busy_cnt, 32'd4);
        @(posedge clk); #1;

        // 5: start held high, three back-to-back ops
        X = 16'h00FF; Y = 16'h0101; sgn = 1'b0; start = 1'b1;
        sb.push_back(32'h0000FFFF);
        @(posedge clk); #1;
        wait_done(cyc);
        chk("held_first", cyc, 32'd4);
        X = 16'hFFFE; Y = 16'h0003; sgn = 1'b1;
        sb.push_back(32'hFFFFFFFA);
        wait_done(cyc);
        chk("held_gap1", cyc, 32'd5);
        X = 16'hABCD; Y = 16'h0010; sgn = 1'b0;
        sb.push_back(32'h000ABCD0);
        wait_done(cyc);
        chk("held_gap2", cyc, 32'd5);
        start = 1'b0;
        @(posedge clk); #1;

        // 6: reset during MC abandons the op
        X = 16'h1111; Y = 16'h2222; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_R", R, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        done_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            done_cnt += done ? 1 : 0;
        end
        chk("midrst_no_done", done_cnt, 32'd0);

        // Random ops against a sign-extended 32-bit reference product
        for (int i = 0; i < 2000; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rs = 1'($urandom);
            issue(rx, ry, rs, ref_mul(rx, ry, rs));
            wait_done(cyc);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
